// File: rtl/zap_branch_state_ctrl_pkg.sv
// Shared branch-state constants and BHT controller FSM encoding.
// Predecode imports these instead of keeping local copies.
package zap_branch_state_ctrl_pkg;
  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } fsm_e;
endpackage

// File: rtl/zap_branch_state_ctrl_if.sv
// Fetch-lookup and ALU-resolve ports of the branch-state controller.
interface zap_branch_state_ctrl_if;
  logic        i_fetch_valid;
  logic [31:0] i_fetch_pc;
  logic        i_fetch_thumb;
  logic        i_upd_valid;
  logic [31:0] i_upd_pc;
  logic        i_upd_thumb;
  logic        i_upd_taken;
  logic [1:0]  o_taken_ff;

  modport master (
    output i_fetch_valid, i_fetch_pc, i_fetch_thumb,
    output i_upd_valid, i_upd_pc, i_upd_thumb, i_upd_taken,
    input  o_taken_ff
  );

  modport slave (
    input  i_fetch_valid, i_fetch_pc, i_fetch_thumb,
    input  i_upd_valid, i_upd_pc, i_upd_thumb, i_upd_taken,
    output o_taken_ff
  );
endinterface

// File: rtl/zap_bht_sat_counter_next.sv
// 2-bit saturating counter next-state: steps toward ST on taken, SNT otherwise.
module zap_bht_sat_counter_next
  import zap_branch_state_ctrl_pkg::*;
(
  input  logic [1:0] i_state,
  input  logic       i_taken,
  output logic [1:0] o_next
);
  always_comb begin
    o_next = i_state;
    if (i_taken) begin
      if (i_state != ST) o_next = i_state + 2'd1;
    end else begin
      if (i_state != SNT) o_next = i_state - 2'd1;
    end
  end
endmodule

// File: rtl/zap_branch_state_ctrl.sv
// Branch-history table of 2-bit counters with init walk, resolve update,
// write-through bypass and the registered branch state handed to predecode.
module zap_branch_state_ctrl
  import zap_branch_state_ctrl_pkg::*;
#(
  parameter int         ENTRIES    = 256,
  parameter int         INDEX_W    = $clog2(ENTRIES),
  parameter logic [1:0] INIT_STATE = WNT
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_init_req,
  input  logic i_stall,
  input  logic i_clear,
  zap_branch_state_ctrl_if.slave bus,
  output logic o_busy
);
  fsm_e               r_state, w_state_nxt;
  logic [INDEX_W-1:0] r_idx, w_idx_nxt;
  logic               w_walk_we;
  logic [1:0]         r_bht [ENTRIES];

  logic [INDEX_W-1:0] w_fetch_idx, w_upd_idx;
  logic [1:0]         w_upd_cur, w_upd_next, w_fetch_raw, w_byp_next, w_lookup;
  logic               w_upd_en;
  logic               w_unused_pc;

  assign w_fetch_idx = bus.i_fetch_thumb ? bus.i_fetch_pc[INDEX_W:1] : bus.i_fetch_pc[INDEX_W+1:2];
  assign w_upd_idx   = bus.i_upd_thumb   ? bus.i_upd_pc[INDEX_W:1]   : bus.i_upd_pc[INDEX_W+1:2];
  assign w_unused_pc = ^{bus.i_fetch_pc, bus.i_upd_pc};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= INIT;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // A request mid-walk restarts from entry 0 rather than queueing a second walk.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_walk_we   = 1'b0;
    case (r_state)
      INIT: begin
        w_walk_we = 1'b1;
        w_idx_nxt = r_idx + 1'b1;
        if (i_init_req)                            w_idx_nxt   = '0;
        else if (r_idx == INDEX_W'(ENTRIES - 1))  w_state_nxt = IDLE;
      end
      IDLE: begin
        if (i_init_req) begin
          w_state_nxt = INIT;
          w_idx_nxt   = '0;
        end
      end
      default: w_state_nxt = INIT;
    endcase
  end

  assign o_busy   = (r_state == INIT);
  assign w_upd_en = (r_state == IDLE) && !i_init_req && bus.i_upd_valid;

  assign w_upd_cur   = r_bht[w_upd_idx];
  assign w_fetch_raw = r_bht[w_fetch_idx];

  zap_bht_sat_counter_next u_upd_next (
    .i_state (w_upd_cur),
    .i_taken (bus.i_upd_taken),
    .o_next  (w_upd_next)
  );

  // Same function on the fetch-side read, selected only when the indices collide.
  zap_bht_sat_counter_next u_byp_next (
    .i_state (w_fetch_raw),
    .i_taken (bus.i_upd_taken),
    .o_next  (w_byp_next)
  );

  always_comb begin
    w_lookup = w_fetch_raw;
    if (r_state == INIT)                                w_lookup = INIT_STATE;
    else if (w_upd_en && (w_upd_idx == w_fetch_idx))    w_lookup = w_byp_next;
  end

  always_ff @(posedge i_clk) begin
    if (w_walk_we)     r_bht[r_idx]     <= INIT_STATE;
    else if (w_upd_en) r_bht[w_upd_idx] <= w_upd_next;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)              bus.o_taken_ff <= SNT;
    else if (i_clear)            bus.o_taken_ff <= SNT;
    else if (i_stall)            bus.o_taken_ff <= bus.o_taken_ff;
    else if (bus.i_fetch_valid)  bus.o_taken_ff <= w_lookup;
    else                         bus.o_taken_ff <= SNT;
  end
endmodule

// File: doc/zap_branch_state_ctrl.md
Name: zap_branch_state_ctrl

Overview:
- Owns the branch-history table (BHT) of 2-bit saturating counters that supplies the 2-bit branch state consumed by predecode and carried down the pipeline.
- Arbitrates one fetch-side lookup port against one ALU-side resolve/update port on the same storage.
- Sequences a table-initialisation walk after reset and on request; lookups during the walk return a fixed default.
- Sits beside fetch; its registered output feeds predecode's branch-state input, aligned with the fetched instruction.

Parameters:
- ENTRIES, 256, number of BHT entries; power of two, 16..1024.
- INDEX_W, $clog2(ENTRIES), table index width (derived; do not override).
- INIT_STATE, 2'd1, value written by the init walk (WNT).

Ports:
- i_clk  input  1  clock.
- i_reset_n  input  1  asynchronous active-low reset.
- i_init_req  input  1  single-cycle pulse; restarts the init walk (mode change, table flush).
- i_fetch_valid  input  1  lookup request this cycle.
- i_fetch_pc  input  32  PC of the instruction being fetched.
- i_fetch_thumb  input  1  1 = Thumb indexing, 0 = ARM indexing.
- i_stall  input  1  OR of all downstream stalls to fetch; holds the output register.
- i_clear  input  1  pipeline clear (writeback or ALU); invalidates the output register.
- i_upd_valid  input  1  branch resolved this cycle.
- i_upd_pc  input  32  PC of the resolved branch.
- i_upd_thumb  input  1  indexing mode of the resolved branch.
- i_upd_taken  input  1  actual outcome: 1 = taken.
- o_taken_ff  output  2  registered branch state for predecode: 0 SNT, 1 WNT, 2 WT, 3 ST.
- o_busy  output  1  init walk in progress.

Behaviour:
- **Reset:** asynchronous, active-low.
  - state = INIT, walk index = 0.
  - o_taken_ff = 2'd0, o_busy = 1.
  - Table contents are undefined until the walk completes.
- **Index:** ARM uses pc[INDEX_W+1:2]; Thumb uses pc[INDEX_W:1]. Applies to both ports.
- **FSM state INIT:**
  - Each cycle writes INIT_STATE to entry[walk index], then increments the index.
  - The cycle that writes entry ENTRIES-1 moves to IDLE.
  - o_busy = 1 throughout INIT and falls on the same edge that enters IDLE. The walk therefore takes exactly ENTRIES cycles.
  - i_init_req during INIT sets the index back to 0; the walk restarts and is not queued.
  - Updates during INIT are dropped.
  - Lookups during INIT return INIT_STATE.
- **FSM state IDLE:**
  - i_init_req moves to INIT with index 0 on the next edge. An update in the same cycle is dropped (init wins).
- **Update (IDLE only):** read-modify-write in one cycle on the update index.
  - taken: counter = min(counter+1, 3).
  - not taken: counter = max(counter-1, 0).
- **Lookup:**
  - Combinational read of the table at the fetch index.
  - If an update targets the same index in the same cycle, the lookup returns the post-update value (write-through bypass).
- **Output register, priority from highest:**
  1. reset.
  2. i_clear: o_taken_ff <= 0.
  3. i_stall: hold.
  4. i_fetch_valid: o_taken_ff <= lookup value.
  5. otherwise: o_taken_ff <= 0.
- **Latency:** 1 cycle from lookup to o_taken_ff.
- **Independence from stall:** updates apply regardless of i_stall and i_clear, because resolved branches always train.
- **Width rules:** counters are exactly 2 bits; saturate, never wrap. Upper PC bits are ignored (aliasing is permitted).

Decomposition:
- Shared package/header: branch-state constants SNT=0, WNT=1, WT=2, ST=3, and the FSM state encodings INIT, IDLE. These replace the local copies currently held in predecode.
- One sub-module, zap_bht_sat_counter_next: combinational 2-bit saturating next-state function (state, taken -> next). Instantiated for the update path and the bypass compare path.
- Table storage and FSM stay in this module.

Test Plan:
- **Init walk:** release reset, ENTRIES=256.
  - o_busy is high for exactly 256 cycles, then low.
  - Lookup at PC 0x0000_0100 during the walk gives o_taken_ff=1 one cycle later.
  - After the walk, every index reads 1.
- **Saturation:** in IDLE, 3 taken updates at ARM PC 0x0000_0040 (index 16).
  - Lookup gives 3; a 4th taken update keeps it at 3.
  - 5 not-taken updates give 0 and it stays 0.
- **Bypass:** entry 16 = 1; update taken at PC 0x40 and lookup PC 0x40 in the same cycle.
  - o_taken_ff = 2 next cycle.
  - Lookup PC 0x44 in the same cycle returns its own value unaffected.
- **Thumb indexing:** taken update with thumb=1 at PC 0x0000_0022 (index 17), starting from 1.
  - ARM lookup at PC 0x44 returns 2.
  - ARM lookup at PC 0x40 stays 1.
- **Stall/clear priority:** o_taken_ff=3, i_stall=1 with a different lookup gives o_taken_ff held at 3.
  - i_clear and i_stall together give 0.
  - During the stall, updates still change the table, which a post-stall lookup confirms.
- **Init collisions:**
  - i_init_req mid-walk at index 100: o_busy lasts a further 256 cycles.
  - i_init_req plus i_upd_valid in IDLE: the update is lost and all entries read 1 after the walk.
  - Async reset asserted mid-walk: o_busy=1 and o_taken_ff=0 immediately, without waiting for a clock edge.
